// File: rtl/io_bridge_pkg.sv
// rtl/io_bridge_pkg.sv - shared constants and types for the timer I/O bridge
package io_bridge_pkg;

  // Default byte base addresses of the two timers (16-byte aligned windows)
  localparam logic [31:0] T0_BASE_DEF = 32'h0000_7F00;
  localparam logic [31:0] T1_BASE_DEF = 32'h0000_7F10;

  // Register index inside a timer window (byte address bits 3:2)
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // MODE encoding; every value other than auto-reload behaves as one-shot
  localparam logic [1:0] MODE_AUTO = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } timer_state_t;

  // Window tag of a byte base address: the bits that select a timer
  function automatic logic [27:0] base_tag(input logic [31:0] base);
    return base[31:4];
  endfunction

endpackage

// File: rtl/io_timer.sv
// rtl/io_timer.sv - one down-counting timer: CTRL/PRESET/COUNT, FSM and irq flag
module io_timer
  import io_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_ctrl,
  input  logic        we_preset,
  input  logic [31:0] wd,
  output logic [3:0]  ctrl,
  output logic [31:0] preset,
  output logic [31:0] count,
  output logic        irq
);

  timer_state_t state;

  logic       en;
  logic [1:0] mode;

  assign en   = ctrl[CTRL_EN];
  assign mode = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];

  // Timer FSM plus CPU register writes; CPU writes are applied last so they win
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ctrl   <= 4'h0;
      preset <= 32'h0;
      count  <= 32'h0;
      irq    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (en) state <= LOAD;
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!en) begin
            state <= IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count <= 32'h0;
            irq   <= 1'b1;
            state <= INT;
          end
        end
        INT: begin
          // Auto-reload keeps EN so IDLE relaunches the count next cycle
          if (mode != MODE_AUTO) ctrl[CTRL_EN] <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (we_ctrl)   ctrl   <= wd[3:0];
      if (we_preset) preset <= wd;
      if (we_ctrl || we_preset) irq <= 1'b0;
    end
  end

endmodule

// File: rtl/io_bridge.sv
// rtl/io_bridge.sv - CPU peripheral bus decode, read mux and interrupt collection for two timers
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter logic [31:0] T0_BASE = T0_BASE_DEF,
  parameter logic [31:0] T1_BASE = T1_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] PrAddr,
  input  logic [31:0] PrWD,
  input  logic        WeCPU,
  output logic [31:0] PrRD,
  output logic [7:2]  HWInt
);

  logic       sel0, sel1;
  logic [1:0] reg_idx;

  logic [3:0]  ctrl0, ctrl1;
  logic [31:0] preset0, preset1;
  logic [31:0] count0, count1;
  logic        irq0, irq1;

  logic we_ctrl0, we_preset0, we_ctrl1, we_preset1;

  // Word address bits 31:4 pick the timer window, bits 3:2 the register
  assign sel0    = (PrAddr[31:4] == base_tag(T0_BASE));
  assign sel1    = (PrAddr[31:4] == base_tag(T1_BASE));
  assign reg_idx = PrAddr[3:2];

  // Only CTRL and PRESET are writable; COUNT and register 3 ignore writes
  assign we_ctrl0   = WeCPU && sel0 && (reg_idx == REG_CTRL);
  assign we_preset0 = WeCPU && sel0 && (reg_idx == REG_PRESET);
  assign we_ctrl1   = WeCPU && sel1 && (reg_idx == REG_CTRL);
  assign we_preset1 = WeCPU && sel1 && (reg_idx == REG_PRESET);

  io_timer u_timer0 (
    .clk       (clk),
    .rst       (rst),
    .we_ctrl   (we_ctrl0),
    .we_preset (we_preset0),
    .wd        (PrWD),
    .ctrl      (ctrl0),
    .preset    (preset0),
    .count     (count0),
    .irq       (irq0)
  );

  io_timer u_timer1 (
    .clk       (clk),
    .rst       (rst),
    .we_ctrl   (we_ctrl1),
    .we_preset (we_preset1),
    .wd        (PrWD),
    .ctrl      (ctrl1),
    .preset    (preset1),
    .count     (count1),
    .irq       (irq1)
  );

  // Zero-latency read mux; anything unmapped reads as zero
  always_comb begin
    PrRD = 32'h0;
    if (sel0) begin
      case (reg_idx)
        REG_CTRL:   PrRD = {28'h0, ctrl0};
        REG_PRESET: PrRD = preset0;
        REG_COUNT:  PrRD = count0;
        default:    PrRD = 32'h0;
      endcase
    end else if (sel1) begin
      case (reg_idx)
        REG_CTRL:   PrRD = {28'h0, ctrl1};
        REG_PRESET: PrRD = preset1;
        REG_COUNT:  PrRD = count1;
        default:    PrRD = 32'h0;
      endcase
    end
  end

  assign HWInt = {4'b0000, ctrl1[CTRL_IM] & irq1, ctrl0[CTRL_IM] & irq0};

endmodule

// File: tb/tb_io_bridge.sv
// tb/tb_io_bridge.sv - directed self-checking bench for io_bridge
module tb_io_bridge;

  logic        clk;
  logic        rst;
  logic [31:2] PrAddr;
  logic [31:0] PrWD;
  logic        WeCPU;
  logic [31:0] PrRD;
  logic [7:2]  HWInt;

  int total;
  int bad;

  io_bridge dut (
    .clk    (clk),
    .rst    (rst),
    .PrAddr (PrAddr),
    .PrWD   (PrWD),
    .WeCPU  (WeCPU),
    .PrRD   (PrRD),
    .HWInt  (HWInt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    PrAddr = a[31:2];
    PrWD   = d;
    WeCPU  = 1'b1;
    @(posedge clk);
    #1;
    WeCPU  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    PrAddr = a[31:2];
    #1;
    chk(tag, PrRD, exp);
  endtask

  task automatic hw(input logic [5:0] exp, input string tag);
    chk(tag, {26'h0, HWInt}, {26'h0, exp});
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b0;
    WeCPU  = 1'b0;
    PrWD   = 32'h0;
    PrAddr = '0;

    // reset state
    step();
    step();
    rd(32'h7F00, 32'h0, "rst_ctrl0");
    rd(32'h7F04, 32'h0, "rst_preset0");
    rd(32'h7F08, 32'h0, "rst_count0");
    hw(6'b000000, "rst_hwint");
    step();
    rd(32'h7F10, 32'h0, "rst_ctrl1");
    @(negedge clk);
    rst = 1'b1;
    step();

    // one-shot with interrupt on timer0
    wr(32'h7F04, 32'd5);
    wr(32'h7F00, 32'h9);
    step();
    rd(32'h7F08, 32'd0, "os_load_cycle");
    for (int k = 0; k < 6; k++) begin
      step();
      rd(32'h7F08, 32'd5 - k, "os_count");
      hw((k == 5) ? 6'b000001 : 6'b000000, "os_hwint");
    end
    step();
    rd(32'h7F00, 32'h8, "os_en_cleared");
    hw(6'b000001, "os_irq_held");

    // flag clear through CTRL write
    wr(32'h7F00, 32'h8);
    hw(6'b000000, "clr_hwint");
    rd(32'h7F00, 32'h8, "clr_ctrl");
    step();
    hw(6'b000000, "clr_hwint_later");
    rd(32'h7F08, 32'h0, "clr_count_idle");

    // auto-reload on timer1 with IM=0
    wr(32'h7F14, 32'd3);
    wr(32'h7F10, 32'h3);
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      rd(32'h7F18, 32'd3 - k, "ar_count");
      hw(6'b000000, "ar_masked");
    end
    step();
    step();
    rd(32'h7F18, 32'd0, "ar_load_cycle");
    step();
    rd(32'h7F18, 32'd3, "ar_reloaded");

    // unmask: the write clears the old flag, next expiry raises HWInt[3]
    wr(32'h7F10, 32'hB);
    rd(32'h7F18, 32'd2, "ar_count_after_im");
    hw(6'b000000, "ar_flag_cleared");
    step();
    rd(32'h7F18, 32'd1, "ar_count_1");
    step();
    rd(32'h7F18, 32'd0, "ar_expired");
    hw(6'b000010, "ar_hwint3");
    step();
    step();
    step();
    rd(32'h7F18, 32'd3, "ar_second_period");
    hw(6'b000010, "ar_flag_sticky");

    // decode: read-only COUNT, register 3, unmapped window, WeCPU=0
    wr(32'h7F08, 32'h1234);
    rd(32'h7F08, 32'h0, "dec_count_ro");
    wr(32'h7F0C, 32'hFFFF_FFFF);
    rd(32'h7F0C, 32'h0, "dec_reg3");
    rd(32'h7F04, 32'd5, "dec_preset_kept");
    rd(32'h7F00, 32'h8, "dec_ctrl_kept");
    wr(32'h7F20, 32'hABCD);
    rd(32'h7F20, 32'h0, "dec_unmapped");
    @(negedge clk);
    PrAddr = 30'(32'h7F04 >> 2);
    PrWD   = 32'h77;
    WeCPU  = 1'b0;
    step();
    rd(32'h7F04, 32'd5, "dec_no_we");
    wr(32'h7F00, 32'hFFFF_FFF0);
    rd(32'h7F00, 32'h0, "dec_ctrl_upper");
    hw(6'b000010, "dec_hwint");

    // PRESET=0 expires one cycle after LOAD
    wr(32'h7F04, 32'd0);
    wr(32'h7F00, 32'h9);
    step();
    step();
    chk("p0_not_yet", {31'h0, HWInt[2]}, 32'h0);
    step();
    chk("p0_expired", {31'h0, HWInt[2]}, 32'h1);
    rd(32'h7F08, 32'h0, "p0_count");
    step();
    rd(32'h7F00, 32'h8, "p0_oneshot_off");

    // PRESET change mid-count, then async reset mid-count
    wr(32'h7F04, 32'd10);
    wr(32'h7F00, 32'h1);
    step();
    step();
    rd(32'h7F08, 32'd10, "mc_loaded");
    step();
    step();
    rd(32'h7F08, 32'd8, "mc_count8");
    wr(32'h7F04, 32'd2);
    rd(32'h7F08, 32'd7, "mc_preset_no_effect");
    rd(32'h7F04, 32'd2, "mc_preset_new");
    #1;
    rst = 1'b0;
    rd(32'h7F08, 32'h0, "ar_rst_count");
    rd(32'h7F04, 32'h0, "ar_rst_preset");
    hw(6'b000000, "ar_rst_hwint");
    #1;
    rst = 1'b1;
    step();
    step();
    rd(32'h7F08, 32'h0, "post_rst_count");
    rd(32'h7F00, 32'h0, "post_rst_ctrl");
    wr(32'h7F04, 32'd2);
    wr(32'h7F00, 32'h1);
    step();
    step();
    rd(32'h7F08, 32'd2, "post_rst_restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
